// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_pkg
// Brief    : Shared configuration type, reset defaults and threshold helper
//            for the clk_div_bank divider channels.
// Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    localparam int CFG_W    = 8;
    localparam int DEF_DIV  = 2;
    localparam int DEF_HIGH = 1;
    localparam int DEF_EN   = 1;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic             en;
    } cfg_t;

    // First count value at which the output is high; one bit wider than the
    // fields so DIV+1 and the clamp against it never wrap.
    function automatic logic [CFG_W:0] high_threshold(input cfg_t c);
        logic [CFG_W:0] period;
        logic [CFG_W:0] heff;
        period = {1'b0, c.div} + (CFG_W+1)'(1);
        heff   = ({1'b0, c.high} > period) ? period : {1'b0, c.high};
        return period - heff;
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_chan
// Brief    : One integer clock divider channel: counter, shadow config,
//            boundary apply logic and registered out/tick.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int RST_DIV  = DEF_DIV,
    parameter int RST_HIGH = DEF_HIGH,
    parameter int RST_EN   = DEF_EN
) (
    input  logic             in,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CFG_W-1:0] wr_div,
    input  logic [CFG_W-1:0] wr_high,
    input  logic             wr_ena,
    input  logic             sync,
    output logic             out,
    output logic             tick,
    output logic             pending
);

    localparam cfg_t C_RST_CFG = '{
        div:  CFG_W'(RST_DIV),
        high: CFG_W'(RST_HIGH),
        en:   (RST_EN != 0)
    };

    cfg_t             r_cfg;
    cfg_t             r_shadow;
    logic [CFG_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_out;
    logic             r_tick;

    cfg_t             w_wr_cfg;
    logic             w_wrap;
    logic             w_apply;
    logic             w_high;

    assign w_wr_cfg = '{div: wr_div, high: wr_high, en: wr_ena};
    assign w_wrap   = r_cfg.en && (r_cnt == r_cfg.div);
    // Config may only change where the period ends, while idle, or on sync,
    // so the output never shows a partial pulse except the sync truncation.
    assign w_apply  = w_wrap || !r_cfg.en || sync;
    assign w_high   = r_cfg.en && ({1'b0, r_cnt} >= high_threshold(r_cfg));

    always_ff @(posedge in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_cfg     <= C_RST_CFG;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_out     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_out  <= w_high;
            r_tick <= r_cfg.en && (r_cnt == '0);
            if (w_apply) begin
                r_cnt     <= '0;
                r_pending <= 1'b0;
                if (wr) begin
                    r_cfg <= w_wr_cfg;
                end else if (r_pending) begin
                    r_cfg <= r_shadow;
                end
            end else begin
                r_cnt <= r_cnt + CFG_W'(1);
                if (wr) begin
                    r_shadow  <= w_wr_cfg;
                    r_pending <= 1'b1;
                end
            end
        end
    end

    assign out     = r_out;
    assign tick    = r_tick;
    assign pending = r_pending;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_bank
// Brief    : Bank of N independently programmable integer clock dividers
//            with shadowed reconfiguration and a global phase sync.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
    parameter int N        = 4,
    parameter int W        = clk_div_pkg::CFG_W,
    parameter int CW       = 2,
    parameter int DEF_DIV  = clk_div_pkg::DEF_DIV,
    parameter int DEF_HIGH = clk_div_pkg::DEF_HIGH,
    parameter int DEF_EN   = clk_div_pkg::DEF_EN
) (
    input  logic          in,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [W-1:0]  wr_div,
    input  logic [W-1:0]  wr_high,
    input  logic          wr_ena,
    input  logic          sync,
    output logic [N-1:0]  out,
    output logic [N-1:0]  tick,
    output logic [N-1:0]  pending
);

    // Selects at or above N match no channel, so such writes are dropped.
    for (genvar i = 0; i < N; i++) begin : g_chan
        logic w_wr;

        assign w_wr = wr_en && (wr_ch == CW'(i));

        clk_div_chan #(
            .RST_DIV  (DEF_DIV),
            .RST_HIGH (DEF_HIGH),
            .RST_EN   (DEF_EN)
        ) u_chan (
            .in      (in),
            .rst_n   (rst_n),
            .wr      (w_wr),
            .wr_div  (wr_div),
            .wr_high (wr_high),
            .wr_ena  (wr_ena),
            .sync    (sync),
            .out     (out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule : clk_div_bank
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Directed self-checking bench for clk_div_bank (N=4 defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [7:0] wr_high;
    logic       wr_ena;
    logic       sync;
    logic [3:0] out;
    logic [3:0] tick;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_bank #(.N(4), .W(8), .CW(2)) dut (
        .in      (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_high (wr_high),
        .wr_ena  (wr_ena),
        .sync    (sync),
        .out     (out),
        .tick    (tick),
        .pending (pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [1:0] ch, input logic [7:0] d,
                               input logic [7:0] h, input logic e);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = d;
        wr_high = h;
        wr_ena  = e;
    endtask

    task automatic test_reset();
        logic [3:0] eo;
        logic [3:0] et;
        rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_high = '0;
        wr_ena = 1'b0; sync = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL reset_out got=%b exp=%b", out, 4'h0); end
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick got=%b exp=%b", tick, 4'h0); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL reset_pending got=%b exp=%b", pending, 4'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            eo = (((e - 1) % 3) == 2) ? 4'hF : 4'h0;
            et = (((e - 1) % 3) == 0) ? 4'hF : 4'h0;
            checks++; if (out !== eo) begin errors++; $display("FAIL default_out e=%0d got=%b exp=%b", e, out, eo); end
            checks++; if (tick !== et) begin errors++; $display("FAIL default_tick e=%0d got=%b exp=%b", e, tick, et); end
            checks++; if (pending !== 4'h0) begin errors++; $display("FAIL default_pending e=%0d got=%b exp=%b", e, pending, 4'h0); end
        end
    endtask

    // ch1 -> DIV=4 HIGH=2 written while cnt=1 of the default period.
    task automatic test_period_change();
        step();
        drive_write(2'd1, 8'd4, 8'd2, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ch1_pending_set got=%b exp=%b", pending, 4'b0010); end
        checks++; if (out[1] !== 1'b0) begin errors++; $display("FAIL ch1_out_old0 got=%b exp=%b", out[1], 1'b0); end
        step();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch1_pending_clr got=%b exp=%b", pending, 4'b0000); end
        checks++; if (out[1] !== 1'b1) begin errors++; $display("FAIL ch1_out_oldlast got=%b exp=%b", out[1], 1'b1); end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++; if (out[1] !== ((k % 5) >= 3)) begin errors++; $display("FAIL ch1_out k=%0d got=%b exp=%b", k, out[1], ((k % 5) >= 3)); end
            checks++; if (tick[1] !== ((k % 5) == 0)) begin errors++; $display("FAIL ch1_tick k=%0d got=%b exp=%b", k, tick[1], ((k % 5) == 0)); end
            checks++; if (out[0] !== (((k + 12) % 3) == 2)) begin errors++; $display("FAIL ch0_undisturbed k=%0d got=%b exp=%b", k, out[0], (((k + 12) % 3) == 2)); end
        end
    endtask

    // ch2: HIGH=0 (constant low), then DIV=3 HIGH=9 (constant high).
    task automatic test_duty_extremes();
        drive_write(2'd2, 8'd2, 8'd0, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ch2_pending_a got=%b exp=%b", pending, 4'b0100); end
        step();
        checks++; if (out[2] !== 1'b1) begin errors++; $display("FAIL ch2_oldlast got=%b exp=%b", out[2], 1'b1); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch2_pending_a_clr got=%b exp=%b", pending, 4'b0000); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (out[2] !== 1'b0) begin errors++; $display("FAIL ch2_const0 k=%0d got=%b exp=%b", k, out[2], 1'b0); end
        end
        drive_write(2'd2, 8'd3, 8'd9, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ch2_pending_b got=%b exp=%b", pending, 4'b0100); end
        checks++; if (out[2] !== 1'b0) begin errors++; $display("FAIL ch2_wait_out got=%b exp=%b", out[2], 1'b0); end
        step();
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ch2_pending_b_hold got=%b exp=%b", pending, 4'b0100); end
        step();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch2_pending_b_clr got=%b exp=%b", pending, 4'b0000); end
        checks++; if (out[2] !== 1'b0) begin errors++; $display("FAIL ch2_apply_out got=%b exp=%b", out[2], 1'b0); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (out[2] !== 1'b1) begin errors++; $display("FAIL ch2_const1 k=%0d got=%b exp=%b", k, out[2], 1'b1); end
            checks++; if (tick[2] !== ((k % 4) == 0)) begin errors++; $display("FAIL ch2_tick k=%0d got=%b exp=%b", k, tick[2], ((k % 4) == 0)); end
        end
    endtask

    // ch3: disable through the shadow, then re-enable with DIV=1 HIGH=1.
    task automatic test_enable();
        drive_write(2'd3, 8'd2, 8'd1, 1'b0);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL ch3_pending_dis got=%b exp=%b", pending, 4'b1000); end
        step();
        checks++; if (out[3] !== 1'b0) begin errors++; $display("FAIL ch3_out_mid got=%b exp=%b", out[3], 1'b0); end
        step();
        checks++; if (out[3] !== 1'b1) begin errors++; $display("FAIL ch3_out_last got=%b exp=%b", out[3], 1'b1); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch3_pending_dis_clr got=%b exp=%b", pending, 4'b0000); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (out[3] !== 1'b0) begin errors++; $display("FAIL ch3_off_out k=%0d got=%b exp=%b", k, out[3], 1'b0); end
            checks++; if (tick[3] !== 1'b0) begin errors++; $display("FAIL ch3_off_tick k=%0d got=%b exp=%b", k, tick[3], 1'b0); end
        end
        drive_write(2'd3, 8'd1, 8'd1, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ch3_enable_immediate got=%b exp=%b", pending, 4'b0000); end
        checks++; if (tick[3] !== 1'b0) begin errors++; $display("FAIL ch3_enable_tick0 got=%b exp=%b", tick[3], 1'b0); end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++; if (out[3] !== ((k % 2) == 1)) begin errors++; $display("FAIL ch3_on_out k=%0d got=%b exp=%b", k, out[3], ((k % 2) == 1)); end
            checks++; if (tick[3] !== ((k % 2) == 0)) begin errors++; $display("FAIL ch3_on_tick k=%0d got=%b exp=%b", k, tick[3], ((k % 2) == 0)); end
        end
    endtask

    // Counts before sync: ch0=1 ch1=0 ch2=3 ch3=1.
    task automatic test_sync();
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        checks++; if (out !== 4'b1100) begin errors++; $display("FAIL sync_pre_out got=%b exp=%b", out, 4'b1100); end
        checks++; if (tick !== 4'b0010) begin errors++; $display("FAIL sync_pre_tick got=%b exp=%b", tick, 4'b0010); end
        step();
        checks++; if (tick !== 4'b1111) begin errors++; $display("FAIL sync_tick_all got=%b exp=%b", tick, 4'b1111); end
        checks++; if (out !== 4'b0100) begin errors++; $display("FAIL sync_out0 got=%b exp=%b", out, 4'b0100); end
        step();
        checks++; if (tick !== 4'b0000) begin errors++; $display("FAIL sync_tick1 got=%b exp=%b", tick, 4'b0000); end
        checks++; if (out !== 4'b1100) begin errors++; $display("FAIL sync_out1 got=%b exp=%b", out, 4'b1100); end
        step();
        checks++; if (tick !== 4'b1000) begin errors++; $display("FAIL sync_tick2 got=%b exp=%b", tick, 4'b1000); end
        checks++; if (out !== 4'b0101) begin errors++; $display("FAIL sync_out2 got=%b exp=%b", out, 4'b0101); end
    endtask

    // ch0: last write wins, then a write landing on the apply edge.
    task automatic test_back_to_back();
        drive_write(2'd0, 8'd5, 8'd0, 1'b1);
        step();
        checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL b2b_pending_first got=%b exp=%b", pending[0], 1'b1); end
        drive_write(2'd0, 8'd1, 8'd1, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL b2b_pending_second got=%b exp=%b", pending[0], 1'b1); end
        step();
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL b2b_pending_clr got=%b exp=%b", pending[0], 1'b0); end
        checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL b2b_oldlast got=%b exp=%b", out[0], 1'b1); end
        step();
        checks++; if (out[0] !== 1'b0) begin errors++; $display("FAIL b2b_new_out0 got=%b exp=%b", out[0], 1'b0); end
        checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL b2b_new_tick0 got=%b exp=%b", tick[0], 1'b1); end
        step();
        checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL b2b_new_out1 got=%b exp=%b", out[0], 1'b1); end
        step();
        drive_write(2'd0, 8'd0, 8'd1, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL same_edge_pending got=%b exp=%b", pending[0], 1'b0); end
        checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL same_edge_out got=%b exp=%b", out[0], 1'b1); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (out[0] !== 1'b1) begin errors++; $display("FAIL div0_out k=%0d got=%b exp=%b", k, out[0], 1'b1); end
            checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL div0_tick k=%0d got=%b exp=%b", k, tick[0], 1'b1); end
        end
    endtask

    // ch1 has a pending write when reset is asserted between edges.
    task automatic test_reset_mid();
        logic [3:0] eo;
        logic [3:0] et;
        drive_write(2'd1, 8'd7, 8'd3, 1'b1);
        step();
        wr_en = 1'b0;
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL rstmid_pending_before got=%b exp=%b", pending, 4'b0010); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out !== 4'h0) begin errors++; $display("FAIL rstmid_out got=%b exp=%b", out, 4'h0); end
        checks++; if (tick !== 4'h0) begin errors++; $display("FAIL rstmid_tick got=%b exp=%b", tick, 4'h0); end
        checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rstmid_pending got=%b exp=%b", pending, 4'h0); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            eo = (((e - 1) % 3) == 2) ? 4'hF : 4'h0;
            et = (((e - 1) % 3) == 0) ? 4'hF : 4'h0;
            checks++; if (out !== eo) begin errors++; $display("FAIL rstmid_default_out e=%0d got=%b exp=%b", e, out, eo); end
            checks++; if (tick !== et) begin errors++; $display("FAIL rstmid_default_tick e=%0d got=%b exp=%b", e, tick, et); end
            checks++; if (pending !== 4'h0) begin errors++; $display("FAIL rstmid_shadow_dropped e=%0d got=%b exp=%b", e, pending, 4'h0); end
        end
    endtask

    initial begin
        test_reset();
        test_period_change();
        test_duty_extremes();
        test_enable();
        test_sync();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_div_bank
`default_nettype wire
